// File: rtl/run_alternate_checker.sv
// Serial run-length checker: tracks lengths of consecutive equal-bit runs and
// flags, registered, when the in-progress run relates to the previous completed
// run under the MODE rule (0 equal, 1 ascending, 2 descending, else equal).
module run_alternate_checker #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned RCNT_W = 16,
  parameter int unsigned MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              number,
  output logic              check,
  output logic [CNT_W-1:0]  run_len,
  output logic [CNT_W-1:0]  prev_len,
  output logic [RCNT_W-1:0] run_cnt,
  output logic              cur_bit,
  output logic              ovf
);

  localparam logic [CNT_W-1:0]  CntMax  = '1;
  localparam logic [RCNT_W-1:0] RcntMax = '1;
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [RCNT_W-1:0] RcntOne = RCNT_W'(1);

  typedef enum logic [1:0] {StIdle, StFirst, StSteady} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   run_len_q, run_len_d;
  logic [CNT_W-1:0]   prev_len_q, prev_len_d;
  logic [RCNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic               cur_bit_q, cur_bit_d;
  logic               ovf_q, ovf_d;
  logic               check_q, check_d;
  logic               mode_ok;

  // Next-state for run tracking; everything holds when in_valid is low.
  always_comb begin
    state_d    = state_q;
    run_len_d  = run_len_q;
    prev_len_d = prev_len_q;
    run_cnt_d  = run_cnt_q;
    cur_bit_d  = cur_bit_q;
    ovf_d      = ovf_q;
    if (in_valid) begin
      case (state_q)
        StIdle: begin
          cur_bit_d = number;
          run_len_d = CntOne;
          state_d   = StFirst;
        end
        default: begin
          if (number == cur_bit_q) begin
            // Saturate rather than wrap; a blocked increment is an overflow.
            if (run_len_q == CntMax) begin
              ovf_d = 1'b1;
            end else begin
              run_len_d = run_len_q + CntOne;
            end
          end else begin
            prev_len_d = run_len_q;
            run_len_d  = CntOne;
            cur_bit_d  = number;
            if (run_cnt_q != RcntMax) begin
              run_cnt_d = run_cnt_q + RcntOne;
            end
            state_d = StSteady;
          end
        end
      endcase
    end
  end

  // Compare rule evaluated on next-state lengths so check lines up with them.
  always_comb begin
    case (MODE)
      1:       mode_ok = run_len_d > prev_len_d;
      2:       mode_ok = run_len_d < prev_len_d;
      default: mode_ok = run_len_d == prev_len_d;
    endcase
  end

  // Check flag: refreshed only on valid cycles; saturated lengths never pass.
  always_comb begin
    check_d = check_q;
    if (in_valid) begin
      check_d = (state_d == StSteady) && (run_len_d != CntMax) &&
                (prev_len_d != CntMax) && mode_ok;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      run_len_q  <= '0;
      prev_len_q <= '0;
      run_cnt_q  <= '0;
      cur_bit_q  <= 1'b0;
      ovf_q      <= 1'b0;
      check_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_len_q  <= run_len_d;
      prev_len_q <= prev_len_d;
      run_cnt_q  <= run_cnt_d;
      cur_bit_q  <= cur_bit_d;
      ovf_q      <= ovf_d;
      check_q    <= check_d;
    end
  end

  assign check    = check_q;
  assign run_len  = run_len_q;
  assign prev_len = prev_len_q;
  assign run_cnt  = run_cnt_q;
  assign cur_bit  = cur_bit_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_run_alternate_checker.sv
// Bench for run_alternate_checker: five instances with different parameters
// share one stimulus stream; each record's expectation is queued when driven
// and compared against the selected instance after the edge.
module tb_run_alternate_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset    = 1'b1;
  logic in_valid = 1'b0;
  logic number   = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic v;
    logic n;
    logic chk;
    int   rl;
    int   pl;
    int   rc;
    logic cb;
    logic ov;
  } vec_t;

  vec_t exp_q[$];

  // Instance 0: MODE 0, defaults
  logic chk0, cb0, ov0;
  logic [7:0] rl0, pl0;
  logic [15:0] rc0;
  run_alternate_checker #(.CNT_W(8), .RCNT_W(16), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .number(number), .check(chk0),
    .run_len(rl0), .prev_len(pl0), .run_cnt(rc0), .cur_bit(cb0), .ovf(ov0));

  // Instance 1: MODE 1 ascending
  logic chk1, cb1, ov1;
  logic [7:0] rl1, pl1;
  logic [15:0] rc1;
  run_alternate_checker #(.CNT_W(8), .RCNT_W(16), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .number(number), .check(chk1),
    .run_len(rl1), .prev_len(pl1), .run_cnt(rc1), .cur_bit(cb1), .ovf(ov1));

  // Instance 2: MODE 2 descending
  logic chk2, cb2, ov2;
  logic [7:0] rl2, pl2;
  logic [15:0] rc2;
  run_alternate_checker #(.CNT_W(8), .RCNT_W(16), .MODE(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .number(number), .check(chk2),
    .run_len(rl2), .prev_len(pl2), .run_cnt(rc2), .cur_bit(cb2), .ovf(ov2));

  // Instance 3: narrow run counter for saturation
  logic chk3, cb3, ov3;
  logic [2:0] rl3, pl3;
  logic [15:0] rc3;
  run_alternate_checker #(.CNT_W(3), .RCNT_W(16), .MODE(0)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .number(number), .check(chk3),
    .run_len(rl3), .prev_len(pl3), .run_cnt(rc3), .cur_bit(cb3), .ovf(ov3));

  // Instance 4: narrow completed-run counter
  logic chk4, cb4, ov4;
  logic [7:0] rl4, pl4;
  logic [1:0] rc4;
  run_alternate_checker #(.CNT_W(8), .RCNT_W(2), .MODE(0)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .number(number), .check(chk4),
    .run_len(rl4), .prev_len(pl4), .run_cnt(rc4), .cur_bit(cb4), .ovf(ov4));

  function automatic vec_t mk(input logic v, input logic n, input logic chk, input int rl,
                              input int pl, input int rc, input logic cb, input logic ov);
    vec_t t;
    t.v = v; t.n = n; t.chk = chk; t.rl = rl; t.pl = pl; t.rc = rc; t.cb = cb; t.ov = ov;
    return t;
  endfunction

  // Drive one cycle, queue its expectation, compare the popped entry after the edge.
  task automatic step(input string name, input int sel, input logic rst, input vec_t t);
    vec_t e;
    logic a_chk, a_cb, a_ov;
    int a_rl, a_pl, a_rc;
    @(negedge clk);
    reset    = rst;
    in_valid = t.v;
    number   = t.n;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    reset = 1'b0;
    case (sel)
      1: begin a_chk = chk1; a_rl = int'(rl1); a_pl = int'(pl1); a_rc = int'(rc1);
               a_cb = cb1; a_ov = ov1; end
      2: begin a_chk = chk2; a_rl = int'(rl2); a_pl = int'(pl2); a_rc = int'(rc2);
               a_cb = cb2; a_ov = ov2; end
      3: begin a_chk = chk3; a_rl = int'(rl3); a_pl = int'(pl3); a_rc = int'(rc3);
               a_cb = cb3; a_ov = ov3; end
      4: begin a_chk = chk4; a_rl = int'(rl4); a_pl = int'(pl4); a_rc = int'(rc4);
               a_cb = cb4; a_ov = ov4; end
      default: begin a_chk = chk0; a_rl = int'(rl0); a_pl = int'(pl0); a_rc = int'(rc0);
               a_cb = cb0; a_ov = ov0; end
    endcase
    e = exp_q.pop_front();
    checks++;
    if (a_chk !== e.chk || a_rl != e.rl || a_pl != e.pl || a_rc != e.rc ||
        a_cb !== e.cb || a_ov !== e.ov) begin
      errors++;
      $display("FAIL %s (dut%0d): got chk=%0b run_len=%0d prev_len=%0d run_cnt=%0d cur_bit=%0b ovf=%0b; want chk=%0b run_len=%0d prev_len=%0d run_cnt=%0d cur_bit=%0b ovf=%0b",
               name, sel, a_chk, a_rl, a_pl, a_rc, a_cb, a_ov,
               e.chk, e.rl, e.pl, e.rc, e.cb, e.ov);
    end
  endtask

  task automatic do_reset(input int sel);
    step("reset", sel, 1'b1, mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0));
  endtask

  vec_t s1[8];
  vec_t s2[4];

  initial begin
    // Scenario 1 vectors (MODE 0): bits 0,0,0,1,1,1,1,0
    s1[0] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    s1[1] = mk(1, 0, 0, 2, 0, 0, 0, 0);
    s1[2] = mk(1, 0, 0, 3, 0, 0, 0, 0);
    s1[3] = mk(1, 1, 0, 1, 3, 1, 1, 0);
    s1[4] = mk(1, 1, 0, 2, 3, 1, 1, 0);
    s1[5] = mk(1, 1, 1, 3, 3, 1, 1, 0);
    s1[6] = mk(1, 1, 0, 4, 3, 1, 1, 0);
    s1[7] = mk(1, 0, 0, 1, 4, 2, 0, 0);
    // Scenario 2 vectors (MODE 1): bits 0,1,1,1
    s2[0] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    s2[1] = mk(1, 1, 0, 1, 1, 1, 1, 0);
    s2[2] = mk(1, 1, 1, 2, 1, 1, 1, 0);
    s2[3] = mk(1, 1, 1, 3, 1, 1, 1, 0);

    // Scenario 1: continuous stream
    do_reset(0);
    for (int i = 0; i < 8; i++) step("mode0_stream", 0, 1'b0, s1[i]);

    // Scenario 2: ascending, then descending on the same bits
    do_reset(1);
    for (int i = 0; i < 4; i++) step("mode1_asc", 1, 1'b0, s2[i]);
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      vec_t t;
      t = s2[i];
      t.chk = 1'b0;
      step("mode2_desc", 2, 1'b0, t);
    end

    // Scenario 3: idle gaps with toggling data must leave everything held
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      step("mode0_gap_bit", 0, 1'b0, s1[i]);
      for (int g = 0; g < 2; g++) begin
        vec_t t;
        t = s1[i];
        t.v = 1'b0;
        t.n = (g == 0) ? ~s1[i].n : s1[i].n;
        step("mode0_gap_hold", 0, 1'b0, t);
      end
    end

    // Scenario 4: CNT_W=3 saturation and sticky ovf
    do_reset(3);
    for (int i = 1; i <= 8; i++)
      step("sat_ones", 3, 1'b0, mk(1, 1, 0, (i > 7) ? 7 : i, 0, 0, 1, (i == 8)));
    for (int i = 1; i <= 7; i++)
      step("sat_zeros", 3, 1'b0, mk(1, 0, 0, i, 7, 1, 0, 1));

    // Scenario 5: reset with a valid bit discards it
    do_reset(0);
    step("pre_reset", 0, 1'b0, mk(1, 0, 0, 1, 0, 0, 0, 0));
    step("pre_reset", 0, 1'b0, mk(1, 0, 0, 2, 0, 0, 0, 0));
    step("pre_reset", 0, 1'b0, mk(1, 1, 0, 1, 2, 1, 1, 0));
    step("pre_reset", 0, 1'b0, mk(1, 1, 1, 2, 2, 1, 1, 0));
    step("reset_valid", 0, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0));
    step("after_reset", 0, 1'b0, mk(1, 1, 0, 1, 0, 0, 1, 0));

    // Scenario 6: RCNT_W=2 saturates the completed-run count
    do_reset(4);
    step("rcnt_sat", 4, 1'b0, mk(1, 0, 0, 1, 0, 0, 0, 0));
    step("rcnt_sat", 4, 1'b0, mk(1, 1, 1, 1, 1, 1, 1, 0));
    step("rcnt_sat", 4, 1'b0, mk(1, 0, 1, 1, 1, 2, 0, 0));
    step("rcnt_sat", 4, 1'b0, mk(1, 1, 1, 1, 1, 3, 1, 0));
    step("rcnt_sat", 4, 1'b0, mk(1, 0, 1, 1, 1, 3, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
